demux_fifo_n: RTL and testbench
===============================

// Module: demux_fifo_n
// PURPOSE
//  Parametrised successor to the 4-way 12-bit class demux.
//  Routes each input word to one of N_CH output channels, selected by class.
//  Each channel has its own DEPTH-entry show-ahead FIFO with valid/ready handshakes on both sides.
//  Sits between the classifier front end and the per-class consumers; it absorbs consumer stalls.
// PARAMETERS
//  DATA_W   12  data word width in bits
//  N_CH     4   number of output channels, 1..2**CLASS_W
//  CLASS_W  2   width of the class select
//  DEPTH    4   entries per channel FIFO; power of 2, >=2
//  localparam ADDR_W = $clog2(DEPTH); occupancy counters are ADDR_W+1 bits
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             asynchronous reset, active-high
//  data_in    in   DATA_W        input word
//  class      in   CLASS_W       target channel of data_in
//  valid_in   in   1             data_in/class valid
//  ready_out  out  1             block can accept the presented word
//  data_out   out  N_CH*DATA_W   head word of channel k at [k*DATA_W +: DATA_W]
//  valid_out  out  N_CH          channel k head valid (FIFO k not empty)
//  ready_in   in   N_CH          consumer k takes head word
//  full       out  N_CH          FIFO k holds DEPTH words
//  err        out  1             1-cycle pulse: word with class >= N_CH discarded
//  drop       out  1             1-cycle pulse: word discarded on full (DEMUX_DROP_EN only)
// BEHAVIOUR
//  Reset (async, immediate):
//   - All pointers and counters clear to 0; contents are lost.
//   - valid_out=0, full=0, err=0, drop=0, data_out=0. Storage array is not reset.
//  Push: valid_in & ready_out at a rising edge -> word written to FIFO[class].
//  ready_out (combinational): 1 when class >= N_CH or full[class]==0. No dependence on ready_in.
//  Out-of-range class: the word is accepted and discarded; err=1 on the following cycle.
//  Pop: valid_out[k] & ready_in[k] at a rising edge -> head k advances. ready_in on an empty channel is ignored.
//  Latency: a word pushed at edge t appears on data_out[k], with valid_out[k]=1, after edge t.
//   No same-cycle bypass.
//  data_out[k] shows the head word when valid_out[k]=1 and is forced to 0 when the channel is empty.
//  Full channel with simultaneous pop: the push is still refused, because ready_out uses the registered full.
//  Push and pop on a non-full channel in the same cycle: occupancy unchanged, order preserved.
//  Channels are independent; at most one push per cycle, up to N_CH pops per cycle.
//  Pointers wrap modulo DEPTH. full[k] asserts when the count is DEPTH. The count never exceeds DEPTH or goes below 0.
//  Strict FIFO order per channel; no reordering across channels is visible.
// CONFIGURATION
//  DEMUX_DROP_EN defined:
//   - ready_out tied to 1.
//   - A word targeting a full channel is discarded, and drop=1 on the next cycle.
//   - The channel contents are unchanged.
//  DEMUX_DROP_EN undefined: backpressure through ready_out as above; drop tied to 0.
// TESTING
//  1. Reset: assert reset mid-stream -> valid_out=0000, full=0000, data_out=0 with no clk edge.
//     After release, the first push is seen alone.
//  2. Routing: push 0x0A1/c0, 0x0B2/c1, 0x0C3/c2, 0x0D4/c3 with ready_in=1111.
//     -> Each word appears on its channel one cycle after its push; valid_out is one-hot.
//  3. Fill: ready_in=0, push 5 words to c2 -> first 4 accepted, full[2]=1, ready_out=0 on the 5th.
//     With DEMUX_DROP_EN: ready_out=1 and drop pulses once.
//  4. Drain order: release ready_in[2] -> data_out[2] yields 4 words in push order, then valid_out[2]=0, data_out=0.
//  5. Concurrent: a push to c1 and a pop from c1 at 2 words occupancy -> count stays 2 and order is preserved across wrap.
//  6. Out of range (N_CH=3, CLASS_W=2): push class=3 -> ready_out=1, err pulses once, no FIFO changes.

Source files
------------

// File: rtl/demux_fifo_n_if.sv
// demux_fifo_n_if: producer/consumer bundle for demux_fifo_n.
// master = producer + consumers side, slave = demux side.
interface demux_fifo_n_if #(
  parameter int DATA_W  = 12,
  parameter int N_CH    = 4,
  parameter int CLASS_W = 2
);
  logic [DATA_W-1:0]      data_in;
  logic [CLASS_W-1:0]     cls;
  logic                   valid_in;
  logic                   ready_out;
  logic [N_CH*DATA_W-1:0] data_out;
  logic [N_CH-1:0]        valid_out;
  logic [N_CH-1:0]        ready_in;
  logic [N_CH-1:0]        full;
  logic                   err;
  logic                   drop;

  modport master (
    output data_in, cls, valid_in, ready_in,
    input  ready_out, data_out, valid_out,
    input  full, err, drop
  );

  modport slave (
    input  data_in, cls, valid_in, ready_in,
    output ready_out, data_out, valid_out,
    output full, err, drop
  );
endinterface

// File: rtl/demux_fifo_n.sv
// demux_fifo_n: class demux into N_CH show-ahead FIFOs.
// Define DEMUX_DROP_EN to discard words for full channels.
module demux_fifo_n #(
  parameter int DATA_W  = 12,
  parameter int N_CH    = 4,
  parameter int CLASS_W = 2,
  parameter int DEPTH   = 4
) (
  input logic          clk,
  input logic          reset,
  demux_fifo_n_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [CLASS_W:0] N_CH_L =
    (CLASS_W+1)'(N_CH);
  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W+1)'(DEPTH);

  logic [N_CH-1:0] push;
  logic [N_CH-1:0] pop;
  logic [N_CH-1:0] valid_v;
  logic [N_CH-1:0] full_v;
  logic            in_range;
  logic            sel_full;
  logic            accept;

  // class decode and full flag of the addressed channel
  always_comb begin
    in_range = ({1'b0, bus.cls} < N_CH_L);
    sel_full = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (bus.cls == CLASS_W'(k))
        sel_full = full_v[k];
    end
  end

`ifdef DEMUX_DROP_EN
  assign bus.ready_out = 1'b1;
`else
  assign bus.ready_out = !in_range || !sel_full;
`endif

  assign accept    = bus.valid_in & bus.ready_out;
  assign bus.valid_out = valid_v;
  assign bus.full      = full_v;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;

    assign valid_v[k] = (cnt != '0);
    assign full_v[k]  = (cnt == DEPTH_L);
    assign push[k] = accept && in_range &&
                     (bus.cls == CLASS_W'(k)) &&
                     !full_v[k];
    assign pop[k]  = valid_v[k] & bus.ready_in[k];
    assign bus.data_out[k*DATA_W +: DATA_W] =
      valid_v[k] ? mem[rd_ptr] : '0;

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[k])
          wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop[k])
          rd_ptr <= rd_ptr + ADDR_W'(1);
        unique case ({push[k], pop[k]})
          2'b10:   cnt <= cnt + (ADDR_W+1)'(1);
          2'b01:   cnt <= cnt - (ADDR_W+1)'(1);
          default: cnt <= cnt;
        endcase
      end
    end

    // storage write, deliberately not reset
    always_ff @(posedge clk) begin
      if (push[k])
        mem[wr_ptr] <= bus.data_in;
    end
  end

  logic err_q;

  // one-cycle pulse for discarded out-of-range words
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= accept & !in_range;
  end

  assign bus.err = err_q;

`ifdef DEMUX_DROP_EN
  logic drop_q;

  // one-cycle pulse for words lost to a full channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_q <= 1'b0;
    else       drop_q <= accept & in_range & sel_full;
  end

  assign bus.drop = drop_q;
`else
  assign bus.drop = 1'b0;
`endif
endmodule

// File: tb/tb_demux_fifo_n.sv
// tb_demux_fifo_n: directed bench for demux_fifo_n.
// Covers N_CH=4 and an N_CH=3 out-of-range instance.
module tb_demux_fifo_n;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  demux_fifo_n_if #(
    .DATA_W(12), .N_CH(4), .CLASS_W(2)
  ) bus_a ();
  demux_fifo_n_if #(
    .DATA_W(12), .N_CH(3), .CLASS_W(2)
  ) bus_b ();

  demux_fifo_n #(
    .DATA_W(12), .N_CH(4),
    .CLASS_W(2), .DEPTH(4)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  demux_fifo_n #(
    .DATA_W(12), .N_CH(3),
    .CLASS_W(2), .DEPTH(4)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [11:0] w;
  logic [63:0] e;

  initial begin
    bus_a.data_in  = '0;
    bus_a.cls      = '0;
    bus_a.valid_in = 1'b0;
    bus_a.ready_in = '0;
    bus_b.data_in  = '0;
    bus_b.cls      = '0;
    bus_b.valid_in = 1'b0;
    bus_b.ready_in = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", 64'(bus_a.valid_out), 0);
    chk("rst_full", 64'(bus_a.full), 0);
    chk("rst_data", 64'(bus_a.data_out), 0);
    chk("rst_err", 64'(bus_a.err), 0);
    chk("rst_drop", 64'(bus_a.drop), 0);

    // 1. reset mid-stream
    bus_a.data_in  = 12'h111;
    bus_a.cls      = 2'd0;
    bus_a.valid_in = 1'b1;
    tick();
    bus_a.valid_in = 1'b0;
    chk("pre_valid", 64'(bus_a.valid_out), 1);
    chk("pre_data", 64'(bus_a.data_out), 64'h111);
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(bus_a.valid_out), 0);
    chk("arst_full", 64'(bus_a.full), 0);
    chk("arst_data", 64'(bus_a.data_out), 0);
    tick();
    reset = 1'b0;
    bus_a.data_in  = 12'h055;
    bus_a.cls      = 2'd3;
    bus_a.valid_in = 1'b1;
    tick();
    bus_a.valid_in = 1'b0;
    chk("first_valid", 64'(bus_a.valid_out), 64'h8);
    e = 64'h055 << 36;
    chk("first_data", 64'(bus_a.data_out), e);
    bus_a.ready_in = 4'b1000;
    tick();
    chk("first_pop", 64'(bus_a.valid_out), 0);

    // 2. routing
    bus_a.ready_in = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      w = 12'h0A1 + 12'(i * 'h11);
      bus_a.data_in  = w;
      bus_a.cls      = 2'(i);
      bus_a.valid_in = 1'b1;
      #1;
      chk("route_rdy", 64'(bus_a.ready_out), 1);
      tick();
      chk("route_valid", 64'(bus_a.valid_out),
          64'(1) << i);
      e = 64'(w) << (12 * i);
      chk("route_data", 64'(bus_a.data_out), e);
    end
    bus_a.valid_in = 1'b0;
    tick();
    chk("route_idle", 64'(bus_a.valid_out), 0);

    // 3. fill channel 2
    bus_a.ready_in = '0;
    for (int j = 0; j < 5; j++) begin
      bus_a.data_in  = 12'h201 + 12'(j);
      bus_a.cls      = 2'd2;
      bus_a.valid_in = 1'b1;
      #1;
`ifdef DEMUX_DROP_EN
      chk("fill_rdy", 64'(bus_a.ready_out), 1);
`else
      chk("fill_rdy", 64'(bus_a.ready_out),
          (j < 4) ? 64'd1 : 64'd0);
`endif
      tick();
      chk("fill_full", 64'(bus_a.full),
          (j >= 3) ? 64'h4 : 64'h0);
`ifdef DEMUX_DROP_EN
      chk("fill_drop", 64'(bus_a.drop),
          (j == 4) ? 64'd1 : 64'd0);
`else
      chk("fill_drop", 64'(bus_a.drop), 0);
`endif
    end
    bus_a.valid_in = 1'b0;
    tick();
    chk("fill_drop_end", 64'(bus_a.drop), 0);
    chk("fill_err", 64'(bus_a.err), 0);

    // 4. drain order
    bus_a.ready_in = 4'b0100;
    for (int j = 0; j < 4; j++) begin
      chk("drain_valid", 64'(bus_a.valid_out), 64'h4);
      e = 64'(12'h201 + 12'(j)) << 24;
      chk("drain_data", 64'(bus_a.data_out), e);
      tick();
    end
    chk("drain_empty", 64'(bus_a.valid_out), 0);
    chk("drain_zero", 64'(bus_a.data_out), 0);
    chk("drain_full", 64'(bus_a.full), 0);

    // 5. concurrent push/pop across wrap
    bus_a.ready_in = '0;
    bus_a.cls      = 2'd1;
    bus_a.valid_in = 1'b1;
    bus_a.data_in  = 12'h301;
    tick();
    bus_a.data_in  = 12'h302;
    tick();
    chk("conc_valid", 64'(bus_a.valid_out), 64'h2);
    chk("conc_head", 64'(bus_a.data_out),
        64'h301 << 12);
    bus_a.ready_in = 4'b0010;
    for (int m = 0; m < 5; m++) begin
      bus_a.data_in = 12'h303 + 12'(m);
      #1;
      chk("conc_rdy", 64'(bus_a.ready_out), 1);
      e = 64'(12'h301 + 12'(m)) << 12;
      chk("conc_data", 64'(bus_a.data_out), e);
      tick();
      chk("conc_full", 64'(bus_a.full), 0);
    end
    bus_a.valid_in = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("conc_vtail", 64'(bus_a.valid_out), 64'h2);
      e = 64'(12'h306 + 12'(m)) << 12;
      chk("conc_tail", 64'(bus_a.data_out), e);
      tick();
    end
    chk("conc_empty", 64'(bus_a.valid_out), 0);
    bus_a.ready_in = '0;

    // 6. out-of-range class on N_CH=3
    bus_b.data_in  = 12'h3FF;
    bus_b.cls      = 2'd3;
    bus_b.valid_in = 1'b1;
    #1;
    chk("oor_rdy", 64'(bus_b.ready_out), 1);
    tick();
    bus_b.valid_in = 1'b0;
    chk("oor_err", 64'(bus_b.err), 1);
    chk("oor_valid", 64'(bus_b.valid_out), 0);
    chk("oor_full", 64'(bus_b.full), 0);
    chk("oor_data", 64'(bus_b.data_out), 0);
    tick();
    chk("oor_err_end", 64'(bus_b.err), 0);
    chk("oor_valid2", 64'(bus_b.valid_out), 0);
    bus_b.data_in  = 12'h123;
    bus_b.cls      = 2'd2;
    bus_b.valid_in = 1'b1;
    tick();
    bus_b.valid_in = 1'b0;
    chk("b_valid", 64'(bus_b.valid_out), 64'h4);
    chk("b_data", 64'(bus_b.data_out),
        64'h123 << 24);
    chk("b_err", 64'(bus_b.err), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
